bi_decoder: RTL and testbench

- Receive-side counterpart of the 32-bit bus-invert flit encoder.
- Each 16-bit lane carries an invert flag in its MSB and 15 payload bits below it. The block restores the payload by XORing the payload bits with the flag.
- Flits are buffered through a 2-entry valid/ready queue, so the block sits between the link receive register and the consumer.
- Per-lane inversion statistics are kept for link power characterisation.

---
 rtl/bi_decoder.sv | 107 ++++++++++
 tb/tb_bi_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bi_decoder.sv
// Bus-invert flit decoder: restores per-lane payloads, buffers them in a
// 2-entry valid/ready queue and keeps per-lane inversion statistics.
module bi_decoder #(
    parameter int LANES  = 2,
    parameter int LANE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*LANE_W-1:0]   in_flit_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*LANE_W-1:0]   out_data_o,
    output logic [LANES-1:0]          out_inv_o,
    input  logic                      clear_stats_i,
    output logic [LANES*CNT_W-1:0]    inv_count_o,
    output logic [CNT_W-1:0]          flit_count_o
);

    localparam int FLIT_W = LANES * LANE_W;

    logic [FLIT_W-1:0]             data_q [2];
    logic [LANES-1:0]              inv_q  [2];
    logic                          wr_ptr_q, rd_ptr_q;
    logic [1:0]                    count_q, count_d;
    logic [CNT_W-1:0]              flit_cnt_q, flit_cnt_d;
    logic [LANES-1:0][CNT_W-1:0]   inv_cnt_q, inv_cnt_d;

    logic [FLIT_W-1:0]             dec_data;
    logic [LANES-1:0]              dec_inv;
    logic                          push, pop;

    // The original lane MSB is never transmitted, so the restored MSB is 0.
    always_comb begin
        dec_data = '0;
        dec_inv  = '0;
        for (int k = 0; k < LANES; k++) begin
            dec_inv[k] = in_flit_i[k*LANE_W + LANE_W-1];
            dec_data[k*LANE_W +: LANE_W] =
                {1'b0, in_flit_i[k*LANE_W +: LANE_W-1] ^ {(LANE_W-1){dec_inv[k]}}};
        end
    end

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready_o   = (count_q != 2'd2);
    assign out_valid_o  = (count_q != 2'd0);
    assign out_data_o   = data_q[rd_ptr_q];
    assign out_inv_o    = inv_q[rd_ptr_q];
    assign inv_count_o  = inv_cnt_q;
    assign flit_count_o = flit_cnt_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Clear wins over a coincident push; the pushed flit is still queued.
    always_comb begin
        flit_cnt_d = flit_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        if (clear_stats_i) begin
            flit_cnt_d = '0;
            inv_cnt_d  = '0;
        end else if (push) begin
            flit_cnt_d = flit_cnt_q + CNT_W'(1);
            for (int k = 0; k < LANES; k++) begin
                if (dec_inv[k] && (inv_cnt_q[k] != {CNT_W{1'b1}}))
                    inv_cnt_d[k] = inv_cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                inv_q[i]  <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            flit_cnt_q <= '0;
            inv_cnt_q  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= dec_data;
                inv_q[wr_ptr_q]  <= dec_inv;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q    <= count_d;
            flit_cnt_q <= flit_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

endmodule

// File: tb/tb_bi_decoder.sv
// Self-checking bench for bi_decoder: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bi_decoder;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_flit;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_inv;
    logic        clear_stats;
    logic [31:0] inv_count;
    logic [15:0] flit_count;

    bi_decoder #(.LANES(2), .LANE_W(16), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_flit_i    (in_flit),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_inv_o    (out_inv),
        .clear_stats_i(clear_stats),
        .inv_count_o  (inv_count),
        .flit_count_o (flit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  inv;
    } ent_t;

    ent_t mq[$];
    int   m_inv[2];
    int   m_flit;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pops     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference decode: each 16-bit lane is a flag (>= 32768) plus 15-bit payload;
    // an inverted payload is restored as 32767 - payload.
    function automatic ent_t model_decode(input logic [31:0] f);
        ent_t e;
        e.d   = '0;
        e.inv = '0;
        for (int k = 0; k < 2; k++) begin
            int lane, p;
            lane = int'((f >> (16 * k)) & 32'hFFFF);
            p    = lane % 32768;
            if (lane >= 32768) begin
                p = 32767 - p;
                e.inv[k] = 1'b1;
            end
            e.d = e.d | (32'(p) << (16 * k));
        end
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inv[0] = 0;
        m_inv[1] = 0;
        m_flit   = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("in_ready",  64'(in_ready),  64'(mq.size() != 2));
        if (mq.size() != 0) begin
            check("out_data", 64'(out_data), 64'(mq[0].d));
            check("out_inv",  64'(out_inv),  64'(mq[0].inv));
        end
        check("flit_count", 64'(flit_count),        64'(m_flit));
        check("inv_count0", 64'(inv_count[15:0]),   64'(m_inv[0]));
        check("inv_count1", 64'(inv_count[31:16]),  64'(m_inv[1]));
    endtask

    // One clock: check at negedge, advance the model, return 1 unit past posedge.
    task automatic step();
        bit   do_push, do_pop;
        ent_t e;
        @(negedge clk);
        check_outputs();
        do_push = in_valid && (mq.size() != 2);
        do_pop  = out_ready && (mq.size() != 0);
        if (do_pop) begin
            e = mq.pop_front();
            pops++;
        end
        e = model_decode(in_flit);
        if (clear_stats) begin
            m_flit   = 0;
            m_inv[0] = 0;
            m_inv[1] = 0;
        end else if (do_push) begin
            m_flit = (m_flit + 1) % 65536;
            for (int k = 0; k < 2; k++)
                if (e.inv[k] && m_inv[k] < 65535) m_inv[k]++;
        end
        if (do_push) mq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0; clear_stats = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_counts",    64'({inv_count, flit_count}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic decode with consumer always ready.
        out_ready = 1'b1;
        push_one(32'h8000_1234);
        check("d1_valid", 64'(out_valid), 64'd1);
        check("d1_data",  64'(out_data),  64'h7FFF_1234);
        check("d1_inv",   64'(out_inv),   64'h2);
        check("d1_invc",  64'(inv_count), 64'h0001_0000);
        check("d1_flitc", 64'(flit_count), 64'd1);
        push_one(32'hFFFF_0000);
        check("d2_data",  64'(out_data),  64'h0000_0000);
        check("d2_inv",   64'(out_inv),   64'h2);
        push_one(32'h8ABC_C123);
        check("d3_data",  64'(out_data),  64'h7543_3EDC);
        check("d3_inv",   64'(out_inv),   64'h3);
        repeat (2) step();

        // Backpressure: fill, hold off a third flit, then drain in order.
        out_ready = 1'b0;
        push_one(32'h0001_0002);
        push_one(32'h0003_0004);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_flit = 32'h0005_0006;
        step();
        check("held_data", 64'(out_data), 64'h0001_0002);
        out_ready = 1'b1;
        step();
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        check("second_data",        64'(out_data), 64'h0003_0004);
        in_valid = 1'b0;
        repeat (3) step();

        // Streaming at one flit per cycle.
        pops = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_flit = $urandom;
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_pops", 64'(pops), 64'd8);
        repeat (2) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            clear_stats = ($urandom_range(0, 40) == 0);
            in_flit     = $urandom;
            step();
        end
        in_valid = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // clear_stats coincident with a push: counters clear, flit still queued.
        clear_stats = 1'b1;
        push_one(32'h8000_1234);
        clear_stats = 1'b0;
        check("clr_counts", 64'({inv_count, flit_count}), 64'd0);
        check("clr_valid",  64'(out_valid), 64'd1);
        check("clr_data",   64'(out_data),  64'h7FFF_1234);
        step();

        // Mid-cycle asynchronous reset with two flits queued.
        out_ready = 1'b0;
        push_one(32'h1111_2222);
        push_one(32'h3333_4444);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_out_data",  64'({out_inv, out_data}), 64'd0);
        check("arst_counts",    64'({inv_count, flit_count}), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step();

        // Saturation of inv_count lane 0 and wrap of flit_count.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            in_flit = $urandom & 32'h7FFF_FFFF | 32'h0000_8000;
            step();
        end
        check("sat_pre_inv0",  64'(inv_count[15:0]), 64'hFFFE);
        check("sat_pre_flit",  64'(flit_count),      64'hFFFE);
        in_flit = 32'h0000_8001;
        step();
        step();
        check("sat_inv0",   64'(inv_count[15:0]), 64'hFFFF);
        check("wrap_flit",  64'(flit_count),      64'h0000);
        step();
        check("sat_hold_inv0", 64'(inv_count[15:0]), 64'hFFFF);
        check("wrap_flit1",    64'(flit_count),      64'h0001);
        in_valid = 1'b0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
